// File: rtl/maverickOne_pkg.sv
// maverickOne_pkg: shared fetch widths, fetch FSM states and default boot address
package maverickOne_pkg;
  localparam int AW = 64;
  localparam int ICDW = 32;
  localparam logic [AW-1:0] BOOT_ADDR_DEFAULT = 64'h0;
  typedef enum logic {IDLE, REQ} fetch_state_e;
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: circular buffer of fetched {pc, instruction} entries with synchronous flush
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 96,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_arst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [CW-1:0] o_count,
  output logic          o_valid,
  output logic [W-1:0]  o_data
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_pop, w_push;
  // a push into a full buffer is legal only when the head leaves in the same cycle
  always_comb begin
    w_pop = i_pop & (r_count != '0);
    w_push = i_push & ((r_count != FULL) | w_pop);
  end
  // pointers and occupancy; flush empties the buffer in one cycle
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == LAST) ? '0 : r_wr + 1'b1;
      if (w_pop) r_rd <= (r_rd == LAST) ? '0 : r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  // storage carries no reset because the head is masked to zero while empty
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_data;
  end
  assign o_count = r_count;
  assign o_valid = r_count != '0;
  assign o_data = o_valid ? r_mem[r_rd] : '0;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch FSM and PC driving the I-Cache, buffering results for decode
module if_stage import maverickOne_pkg::*; #(
  parameter logic [AW-1:0] BOOT_ADDR = BOOT_ADDR_DEFAULT,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            arst_i,
  output logic            icache_req_o,
  output logic [AW-1:0]   icache_addr_o,
  input  logic [ICDW-1:0] icache_data_i,
  input  logic            icache_gnt_i,
  input  logic            redirect_i,
  input  logic [AW-1:0]   redirect_pc_i,
  input  logic            halt_i,
  output logic            instr_valid_o,
  output logic [ICDW-1:0] instr_o,
  output logic [AW-1:0]   instr_pc_o,
  input  logic            instr_ready_i
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  fetch_state_e r_state, w_state_next;
  logic [AW-1:0] r_pc, w_pc_next;
  logic [CW-1:0] w_count, w_count_next;
  logic w_valid, w_pop, w_push, w_space;
  logic [AW+ICDW-1:0] w_head;
  // next state and fetch PC; redirect wins over any grant or pop in the same cycle
  always_comb begin
    w_pop = w_valid & instr_ready_i;
    w_push = (r_state == REQ) & icache_gnt_i & ~redirect_i;
    w_space = (w_count < FULL) | w_pop;
    w_count_next = w_count + CW'(w_push) - CW'(w_pop);
    w_state_next = r_state;
    w_pc_next = r_pc;
    if (redirect_i) begin
      w_state_next = halt_i ? IDLE : REQ;
      w_pc_next = {redirect_pc_i[AW-1:2], 2'b00};
    end else if (r_state == IDLE) begin
      w_state_next = (!halt_i && w_space) ? REQ : IDLE;
    end else if (icache_gnt_i) begin
      w_state_next = (!halt_i && w_count_next < FULL) ? REQ : IDLE;
      w_pc_next = r_pc + 64'd4;
    end
  end
  // state and PC registers; reset drops any outstanding request immediately
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= IDLE;
      r_pc <= BOOT_ADDR;
    end else begin
      r_state <= w_state_next;
      r_pc <= w_pc_next;
    end
  end
  instr_fifo #(.DEPTH(FIFO_DEPTH), .W(AW + ICDW), .CW(CW)) u_fifo (
    .i_clk(clk_i),
    .i_arst(arst_i),
    .i_flush(redirect_i),
    .i_push(w_push),
    .i_data({r_pc, icache_data_i}),
    .i_pop(w_pop & ~redirect_i),
    .o_count(w_count),
    .o_valid(w_valid),
    .o_data(w_head)
  );
  assign icache_req_o = r_state == REQ;
  assign icache_addr_o = r_pc;
  assign instr_valid_o = w_valid;
  assign {instr_pc_o, instr_o} = w_head;
  a_no_overflow: assert property (@(posedge clk_i) disable iff (arst_i) !(w_push && w_count == FULL && !w_pop));
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: table vectors, directed corner sequences and an in-order scoreboard for if_stage
module tb_if_stage;
  typedef struct {
    logic gnt;
    logic rdy;
    logic req;
    logic [63:0] addr;
    logic vld;
    logic [63:0] pc;
  } vec_t;
  typedef struct {
    logic [63:0] pc;
    logic [31:0] word;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  logic gnt = 1'b0, rdy = 1'b0, halt = 1'b0, redir = 1'b0;
  logic [63:0] rpc = 64'h0;
  logic [31:0] data = 32'h0;
  logic req, vld;
  logic [63:0] addr, ipc;
  logic [31:0] instr;
  logic w_req, w_vld;
  logic [63:0] w_addr, w_ipc;
  logic [31:0] w_instr;
  int n_tests = 0;
  int n_fail = 0;
  exp_t q[$];
  logic [63:0] m_pc = 64'h0;
  vec_t tbl[9];
  always #5 clk = ~clk;
  if_stage u_dut (
    .clk_i(clk), .arst_i(rst), .icache_req_o(req), .icache_addr_o(addr),
    .icache_data_i(data), .icache_gnt_i(gnt), .redirect_i(redir), .redirect_pc_i(rpc),
    .halt_i(halt), .instr_valid_o(vld), .instr_o(instr), .instr_pc_o(ipc), .instr_ready_i(rdy)
  );
  if_stage #(.BOOT_ADDR(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk_i(clk), .arst_i(rst2), .icache_req_o(w_req), .icache_addr_o(w_addr),
    .icache_data_i(32'h0), .icache_gnt_i(1'b1), .redirect_i(1'b0), .redirect_pc_i(64'h0),
    .halt_i(1'b0), .instr_valid_o(w_vld), .instr_o(w_instr), .instr_pc_o(w_ipc), .instr_ready_i(1'b1)
  );
  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'h13A5_5A31;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    data = word_of(addr);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    gnt = 1'b0;
    rdy = 1'b0;
    halt = 1'b0;
    redir = 1'b0;
    rpc = 64'h0;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_req", {63'h0, req}, 64'h0);
    chk("rst_addr", addr, 64'h0);
    chk("rst_valid", {63'h0, vld}, 64'h0);
    chk("rst_instr", {32'h0, instr}, 64'h0);
    chk("rst_ipc", ipc, 64'h0);
    cyc();
    rst = 1'b0;
  endtask
  // scoreboard: grants queue the bench's own predicted {pc, word}; deliveries must match in order
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_pc = 64'h0;
    end else if (redir) begin
      q.delete();
      m_pc = {rpc[63:2], 2'b00};
    end else begin
      if (vld && rdy) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got pc %h with nothing outstanding", ipc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_pc", ipc, e.pc);
          chk("sb_instr", {32'h0, instr}, {32'h0, e.word});
        end
      end
      if (req && gnt) begin
        chk("sb_addr", addr, m_pc);
        q.push_back('{m_pc, word_of(m_pc)});
        m_pc = m_pc + 64'd4;
      end
    end
  end
  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 64'h0, 1'b0, 64'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 64'h4, 1'b1, 64'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 64'h8, 1'b1, 64'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 64'h8, 1'b1, 64'h0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 64'h8, 1'b1, 64'h4};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 64'hC, 1'b1, 64'h8};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 64'h10, 1'b1, 64'hC};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 64'h10, 1'b0, 64'h0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      gnt = tbl[i].gnt;
      rdy = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_req", i), {63'h0, req}, {63'h0, tbl[i].req});
      chk($sformatf("tbl%0d_addr", i), addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), {63'h0, vld}, {63'h0, tbl[i].vld});
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_ipc", i), ipc, tbl[i].pc);
        chk($sformatf("tbl%0d_instr", i), {32'h0, instr}, {32'h0, word_of(tbl[i].pc)});
      end
      cyc();
    end
    do_reset();
    rdy = 1'b1;
    @(negedge clk);
    chk("stall_c0_req", {63'h0, req}, 64'h0);
    cyc();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall_c%0d_req", k), {63'h0, req}, 64'h1);
      chk($sformatf("stall_c%0d_addr", k), addr, 64'h0);
      cyc();
    end
    gnt = 1'b1;
    @(negedge clk);
    chk("stall_gnt_addr", addr, 64'h0);
    cyc();
    gnt = 1'b0;
    @(negedge clk);
    chk("stall_after_valid", {63'h0, vld}, 64'h1);
    chk("stall_after_ipc", ipc, 64'h0);
    chk("stall_after_addr", addr, 64'h4);
    cyc();
    @(negedge clk);
    chk("stall_single_push", {63'h0, vld}, 64'h0);
    do_reset();
    gnt = 1'b1;
    cyc();
    cyc();
    cyc();
    redir = 1'b1;
    rpc = 64'h8000_0003;
    rdy = 1'b1;
    @(negedge clk);
    chk("redir_full_valid", {63'h0, vld}, 64'h1);
    chk("redir_full_req", {63'h0, req}, 64'h0);
    cyc();
    redir = 1'b0;
    @(negedge clk);
    chk("redir_flush_valid", {63'h0, vld}, 64'h0);
    chk("redir_new_req", {63'h0, req}, 64'h1);
    chk("redir_new_addr", addr, 64'h8000_0000);
    cyc();
    gnt = 1'b0;
    @(negedge clk);
    chk("redir_first_ipc", ipc, 64'h8000_0000);
    chk("redir_first_instr", {32'h0, instr}, {32'h0, word_of(64'h8000_0000)});
    cyc();
    do_reset();
    rdy = 1'b1;
    cyc();
    halt = 1'b1;
    @(negedge clk);
    chk("halt_c1_req", {63'h0, req}, 64'h1);
    cyc();
    @(negedge clk);
    chk("halt_c2_req", {63'h0, req}, 64'h1);
    chk("halt_c2_addr", addr, 64'h0);
    cyc();
    gnt = 1'b1;
    cyc();
    @(negedge clk);
    chk("halt_drop_req", {63'h0, req}, 64'h0);
    chk("halt_drop_addr", addr, 64'h4);
    chk("halt_drop_valid", {63'h0, vld}, 64'h1);
    cyc();
    gnt = 1'b0;
    halt = 1'b0;
    @(negedge clk);
    chk("halt_idle_req", {63'h0, req}, 64'h0);
    cyc();
    @(negedge clk);
    chk("halt_resume_req", {63'h0, req}, 64'h1);
    chk("halt_resume_addr", addr, 64'h4);
    cyc();
    do_reset();
    gnt = 1'b1;
    rdy = 1'b1;
    @(negedge clk);
    chk("stream_c0_req", {63'h0, req}, 64'h0);
    cyc();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("stream_c%0d_req", k), {63'h0, req}, 64'h1);
      chk($sformatf("stream_c%0d_addr", k), addr, 64'(4 * (k - 1)));
      chk($sformatf("stream_c%0d_valid", k), {63'h0, vld}, {63'h0, k >= 2});
      if (k >= 2) chk($sformatf("stream_c%0d_ipc", k), ipc, 64'(4 * (k - 2)));
      cyc();
    end
    redir = 1'b1;
    rpc = 64'h103;
    cyc();
    redir = 1'b0;
    @(negedge clk);
    chk("stream_redir_valid", {63'h0, vld}, 64'h0);
    chk("stream_redir_addr", addr, 64'h100);
    cyc();
    @(negedge clk);
    chk("stream_redir_ipc0", ipc, 64'h100);
    cyc();
    @(negedge clk);
    chk("stream_redir_ipc1", ipc, 64'h104);
    cyc();
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_req", {63'h0, req}, 64'h0);
    chk("async_rst_addr", addr, 64'h0);
    chk("async_rst_valid", {63'h0, vld}, 64'h0);
    cyc();
    chk("wrap_rst_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    rst2 = 1'b0;
    @(negedge clk);
    chk("wrap_c0_req", {63'h0, w_req}, 64'h0);
    cyc();
    @(negedge clk);
    chk("wrap_c1_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc();
    @(negedge clk);
    chk("wrap_c2_addr", w_addr, 64'h0);
    chk("wrap_c2_ipc", w_ipc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_c2_valid", {63'h0, w_vld}, 64'h1);
    chk("wrap_c2_instr", {32'h0, w_instr}, 64'h0);
    cyc();
    @(negedge clk);
    chk("wrap_c3_addr", w_addr, 64'h4);
    chk("wrap_c3_ipc", w_ipc, 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
